sw_debounce_ctr: RTL and testbench

Parametrised multi-channel switch debouncer, successor to the single-stage sample-and-AND debouncer. Each channel passes through a 2-FF synchroniser, then a per-channel stability counter advanced on a sample-enable tick. A channel's output changes only after the synchronised input has differed from it for STABLE_N consecutive ticks. One-cycle rise/fall pulses are emitted per channel, so downstream logic needs no separate edge detector. It sits between board switches/keys and the control FSMs, running on the fast system clock with a slow tick.

---
 rtl/sw_debounce_pkg.sv | 13 +
 rtl/sw_debounce_ctr_if.sv | 26 ++
 rtl/debounce_ch.sv | 54 +++++
 rtl/sw_debounce_ctr.sv | 46 ++++
 tb/tb_sw_debounce_ctr.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared debouncer constants and counter sizing.
// Defaults match the tick-divider configuration; no latency or backpressure here.
package sw_debounce_pkg;

  localparam int DEF_CH       = 10;
  localparam int DEF_STABLE_N = 4;

  // Width that holds 0..stable_n; cnt itself never exceeds stable_n-1.
  function automatic int cnt_w(input int stable_n);
    return $clog2(stable_n + 1);
  endfunction

endpackage

// File: rtl/sw_debounce_ctr_if.sv
// Switch-in / debounced-level-and-pulse-out bundle for sw_debounce_ctr.
// Pure wiring; no latency, no backpressure (inputs sampled every clk).
interface sw_debounce_ctr_if
  import sw_debounce_pkg::*;
#(
  parameter int CH = DEF_CH
);

  logic          iTick;
  logic [CH-1:0] iSW;
  logic [CH-1:0] oSW_d;
  logic [CH-1:0] oRise;
  logic [CH-1:0] oFall;
  logic          oChg;

  modport master (
    output iTick, iSW,
    input  oSW_d, oRise, oFall, oChg
  );

  modport slave (
    input  iTick, iSW,
    output oSW_d, oRise, oFall, oChg
  );

endinterface

// File: rtl/debounce_ch.sv
// One debounce channel: 2-FF sync, tick-driven stability counter, level and edge pulses.
// Latency 2 clk + STABLE_N ticks; no backpressure, pulses are exactly one clk wide.
module debounce_ch
  import sw_debounce_pkg::*;
#(
  parameter int   STABLE_N = DEF_STABLE_N,
  parameter logic RST_BIT  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sw_in,
  output logic sw_d,
  output logic rise,
  output logic fall
);

  localparam int             CNT_W = cnt_w(STABLE_N);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(STABLE_N - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= RST_BIT;
      s2   <= RST_BIT;
      sw_d <= RST_BIT;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= sw_in;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (tick) begin
        if (s2 == sw_d) begin
          // A bounce back to the current level throws away any progress.
          cnt <= '0;
        end else if (cnt == LAST) begin
          sw_d <= s2;
          cnt  <= '0;
          rise <= s2;
          fall <= ~s2;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/sw_debounce_ctr.sv
// Multi-channel switch debouncer: CH independent debounce_ch slices plus a combined change flag.
// Latency 2 clk + STABLE_N ticks per channel; no backpressure, oChg is combinational from registered pulses.
module sw_debounce_ctr
  import sw_debounce_pkg::*;
#(
  parameter int            CH       = DEF_CH,
  parameter int            STABLE_N = DEF_STABLE_N,
  parameter logic [CH-1:0] RST_VAL  = {CH{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  sw_debounce_ctr_if.slave   bus
);

  if (CH < 1) begin : g_bad_ch
    $error("sw_debounce_ctr: CH must be >= 1");
  end
  if (STABLE_N < 1) begin : g_bad_stable
    $error("sw_debounce_ctr: STABLE_N must be >= 1");
  end

  logic [CH-1:0] sw_d;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    debounce_ch #(
      .STABLE_N (STABLE_N),
      .RST_BIT  (RST_VAL[i])
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .tick  (bus.iTick),
      .sw_in (bus.iSW[i]),
      .sw_d  (sw_d[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  assign bus.oSW_d = sw_d;
  assign bus.oRise = rise;
  assign bus.oFall = fall;
  assign bus.oChg  = |(rise | fall);

endmodule

// File: tb/tb_sw_debounce_ctr.sv
// Bench for sw_debounce_ctr (CH=4, STABLE_N=3): directed scenarios plus random stimulus
// checked every cycle against a window-of-ticks reference model.
module tb_sw_debounce_ctr;
  import sw_debounce_pkg::*;

  localparam int CH = 4;
  localparam int N  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sw_debounce_ctr_if #(.CH(CH)) bus ();

  sw_debounce_ctr #(
    .CH       (CH),
    .STABLE_N (N),
    .RST_VAL  (4'b0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int tick_mode = 0;

  // Reference model: sync delay line, then a record of s2 samples seen on ticks.
  logic [CH-1:0] m_s1, m_s2, m_out, m_rise, m_fall;
  logic [CH-1:0] hq[$];
  int            since [CH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0;
    hq.delete();
    for (int i = 0; i < CH; i++) since[i] = 0;
  endtask

  // A channel flips once its last N tick samples since the previous flip all disagree with it.
  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      m_rise = '0;
      m_fall = '0;
      if (bus.iTick) begin
        hq.push_back(m_s2);
        if (hq.size() > N) void'(hq.pop_front());
        for (int i = 0; i < CH; i++) begin
          bit all_diff;
          since[i]++;
          if (since[i] >= N) begin
            all_diff = 1'b1;
            for (int k = 0; k < N; k++)
              if (hq[hq.size() - 1 - k][i] == m_out[i]) all_diff = 1'b0;
            if (all_diff) begin
              m_out[i]  = ~m_out[i];
              m_rise[i] = m_out[i];
              m_fall[i] = ~m_out[i];
              since[i]  = 0;
            end
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = bus.iSW;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk("sw_d", 32'(bus.oSW_d), 32'(m_out));
    chk("rise", 32'(bus.oRise), 32'(m_rise));
    chk("fall", 32'(bus.oFall), 32'(m_fall));
    chk("chg",  32'(bus.oChg),  32'(|(m_rise | m_fall)));
    case (tick_mode)
      0:       bus.iTick = 1'b1;
      1:       bus.iTick = (cyc % 5 == 0);
      default: bus.iTick = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Steps until channel ch shows level v; returns edges taken (bounded).
  task automatic measure(input int ch, input logic v, output int lat);
    lat = 0;
    while (lat < 20) begin
      step();
      lat++;
      if (bus.oSW_d[ch] == v) break;
    end
  endtask

  task automatic async_reset_check();
    #3;
    rst = 1'b1;
    #1;
    chk("arst_sw_d", 32'(bus.oSW_d), 32'h0);
    chk("arst_rise", 32'(bus.oRise), 32'h0);
    chk("arst_fall", 32'(bus.oFall), 32'h0);
    model_reset();
  endtask

  initial begin
    int lat, cnt_p, chg_n;
    logic [CH-1:0] seen;
    bus.iTick = 1'b1;
    bus.iSW   = '0;
    model_reset();
    run(3);
    rst = 1'b0;

    // Clean step on channel 0.
    bus.iSW[0] = 1'b1;
    measure(0, 1'b1, lat);
    chk("lat_clean", 32'(lat), 32'(N + 2));
    chk("clean_rise0", 32'(bus.oRise), 32'b0001);
    run(4);

    // Bounce on channel 1 (2-clk pieces never reach N ticks), then a stable 1.
    for (int r = 0; r < 6; r++) begin
      bus.iSW[1] = ~r[0];
      run(2);
      chk("bounce_hold", 32'(bus.oSW_d[1]), 32'h0);
    end
    bus.iSW[1] = 1'b1;
    measure(1, 1'b1, lat);
    chk("lat_bounce", 32'(lat), 32'(N + 2));
    run(3);

    // Sparse tick on channel 2: exactly one rise pulse.
    tick_mode = 1;
    bus.iSW[2] = 1'b1;
    cnt_p = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.oRise[2]) cnt_p++;
    end
    chk("sparse_pulses", 32'(cnt_p), 32'h1);
    chk("sparse_level", 32'(bus.oSW_d[2]), 32'h1);
    tick_mode = 0;
    bus.iTick = 1'b1;

    // Simultaneous acceptance.
    bus.iSW = '0;
    run(8);
    bus.iSW = 4'b1111;
    chg_n = 0; seen = '0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.oChg) begin chg_n++; seen = bus.oRise; end
    end
    chk("simul_chg_cyc", 32'(chg_n), 32'h1);
    chk("simul_rise", 32'(seen), 32'b1111);
    bus.iSW = 4'b0101;
    chg_n = 0; seen = '0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.oChg) begin chg_n++; seen = bus.oFall; end
    end
    chk("simul_fall_cyc", 32'(chg_n), 32'h1);
    chk("simul_fall", 32'(seen), 32'b1010);

    // Async reset with outputs at 1010.
    bus.iSW = 4'b1010;
    run(8);
    chk("pre_rst", 32'(bus.oSW_d), 32'b1010);
    async_reset_check();
    bus.iSW = '0;
    run(2);
    rst = 1'b0;
    run(4);

    // Reset mid-count: latency restarts from release.
    bus.iSW[3] = 1'b1;
    run(4);
    async_reset_check();
    run(1);
    rst = 1'b0;
    measure(3, 1'b1, lat);
    chk("lat_after_rst", 32'(lat), 32'(N + 2));
    run(3);

    // Random phase: slowly varying inputs, both dense and random ticks.
    for (int ph = 0; ph < 2; ph++) begin
      tick_mode = ph == 0 ? 0 : 2;
      for (int k = 0; k < 400; k++) begin
        if ($urandom_range(0, 3) == 0) bus.iSW[$urandom_range(0, CH - 1)] ^= 1'b1;
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
